// File: rtl/halt_tag_lookup_ctrl.sv
// Lookup/refill controller for one 4-way set of a way-halting cache.
// Halt tags pre-filter ways so the wide main-tag compare only runs on survivors.
//
// state  | meaning
// IDLE   | ready for a lookup; latches lkp_tag on accept
// HALT   | register per-way halt-tag match vector
// CMP    | main-tag compare on surviving ways; hit or pick refill victim
// REFILL | memory refill handshake, wait for mem_ack
// WRITE  | install latched tag into victim way
// RESP   | one-cycle response strobe
module halt_tag_lookup_ctrl #(
    parameter int HALT_W = 4,
    parameter int MAIN_W = 20,
    parameter int CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       lkp_valid,
    output logic                       lkp_ready,
    input  logic [HALT_W+MAIN_W-1:0]   lkp_tag,
    input  logic [3:0]                 way_valid,
    input  logic [4*HALT_W-1:0]        halt_tag_i,
    input  logic [4*MAIN_W-1:0]        main_tag_i,
    output logic                       resp_valid,
    output logic                       hit,
    output logic                       miss,
    output logic [1:0]                 hit_way,
    output logic                       mem_req,
    output logic [HALT_W+MAIN_W-1:0]   mem_tag,
    input  logic                       mem_ack,
    output logic                       tag_we,
    output logic [3:0]                 way_sel,
    output logic [HALT_W-1:0]          wr_halt_tag,
    output logic [MAIN_W-1:0]          wr_main_tag,
    output logic [CNT_W-1:0]           main_cmp_cnt,
    output logic                       multi_hit
);
    localparam int TAG_W = HALT_W + MAIN_W;

    typedef enum logic [2:0] {
        S_IDLE, S_HALT, S_CMP, S_REFILL, S_WRITE, S_RESP
    } state_t;

    state_t             state_q, state_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [3:0]         halt_match_q, halt_match_d;
    logic [1:0]         rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               multi_hit_q, multi_hit_d;
    logic               hit_q, hit_d;
    logic [1:0]         way_q, way_d;

    logic [HALT_W-1:0]  lkp_halt;
    logic [MAIN_W-1:0]  lkp_main;
    logic [3:0]         halt_eq;
    logic [3:0]         main_match;
    logic [2:0]         match_pop;
    logic [CNT_W:0]     cnt_sum;
    logic [CNT_W-1:0]   cnt_sat;
    logic [1:0]         first_way;
    logic [1:0]         victim;
    logic               any_invalid;

    assign lkp_halt = tag_q[HALT_W-1:0];
    assign lkp_main = tag_q[TAG_W-1:HALT_W];

    always_comb begin
        halt_eq    = '0;
        main_match = '0;
        for (int w = 0; w < 4; w++) begin
            halt_eq[w]    = way_valid[w] && (halt_tag_i[w*HALT_W +: HALT_W] == lkp_halt);
            main_match[w] = halt_match_q[w] && (main_tag_i[w*MAIN_W +: MAIN_W] == lkp_main);
        end
    end

    always_comb begin
        match_pop = 3'({2'b00, halt_match_q[0]}) + 3'({2'b00, halt_match_q[1]})
                  + 3'({2'b00, halt_match_q[2]}) + 3'({2'b00, halt_match_q[3]});
        cnt_sum   = {1'b0, cnt_q} + (CNT_W+1)'(match_pop);
        cnt_sat   = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    end

    // Lowest-index priority for both the hit way and the invalid-way victim.
    always_comb begin
        first_way   = 2'd0;
        victim      = rr_ptr_q;
        any_invalid = ~&way_valid;
        for (int w = 3; w >= 0; w--) begin
            if (main_match[w]) first_way = 2'(w);
            if (!way_valid[w]) victim = 2'(w);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            tag_q        <= '0;
            halt_match_q <= '0;
            rr_ptr_q     <= '0;
            cnt_q        <= '0;
            multi_hit_q  <= 1'b0;
            hit_q        <= 1'b0;
            way_q        <= '0;
        end else begin
            state_q      <= state_d;
            tag_q        <= tag_d;
            halt_match_q <= halt_match_d;
            rr_ptr_q     <= rr_ptr_d;
            cnt_q        <= cnt_d;
            multi_hit_q  <= multi_hit_d;
            hit_q        <= hit_d;
            way_q        <= way_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        tag_d        = tag_q;
        halt_match_d = halt_match_q;
        rr_ptr_d     = rr_ptr_q;
        cnt_d        = cnt_q;
        multi_hit_d  = multi_hit_q;
        hit_d        = hit_q;
        way_d        = way_q;
        lkp_ready    = 1'b0;
        resp_valid   = 1'b0;
        hit          = 1'b0;
        miss         = 1'b0;
        hit_way      = '0;
        mem_req      = 1'b0;
        mem_tag      = '0;
        tag_we       = 1'b0;
        way_sel      = '0;
        wr_halt_tag  = '0;
        wr_main_tag  = '0;

        unique case (state_q)
            S_IDLE: begin
                lkp_ready = 1'b1;
                if (lkp_valid) begin
                    tag_d   = lkp_tag;
                    state_d = S_HALT;
                end
            end
            S_HALT: begin
                halt_match_d = halt_eq;
                state_d      = S_CMP;
            end
            S_CMP: begin
                if (halt_match_q != 4'b0000) cnt_d = cnt_sat;
                if (main_match != 4'b0000) begin
                    hit_d   = 1'b1;
                    way_d   = first_way;
                    state_d = S_RESP;
                    if ((main_match & (main_match - 4'd1)) != 4'b0000) multi_hit_d = 1'b1;
                end else begin
                    hit_d   = 1'b0;
                    way_d   = victim;
                    state_d = S_REFILL;
                    if (!any_invalid) rr_ptr_d = rr_ptr_q + 2'd1;
                end
            end
            S_REFILL: begin
                mem_req = 1'b1;
                mem_tag = tag_q;
                if (mem_ack) state_d = S_WRITE;
            end
            S_WRITE: begin
                tag_we      = 1'b1;
                way_sel     = 4'b0001 << way_q;
                wr_halt_tag = lkp_halt;
                wr_main_tag = lkp_main;
                state_d     = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                hit        = hit_q;
                miss       = ~hit_q;
                hit_way    = way_q;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign main_cmp_cnt = cnt_q;
    assign multi_hit    = multi_hit_q;

endmodule

// File: tb/tb_halt_tag_lookup_ctrl.sv
// Directed bench for halt_tag_lookup_ctrl: behavioural tag arrays plus a
// response scoreboard filled at lookup issue and drained on resp_valid.
module tb_halt_tag_lookup_ctrl;
    localparam int HALT_W = 4;
    localparam int MAIN_W = 20;
    localparam int CNT_W  = 16;
    localparam int TAG_W  = HALT_W + MAIN_W;

    logic              clk;
    logic              reset;
    logic              lkp_valid;
    logic              lkp_ready;
    logic [TAG_W-1:0]  lkp_tag;
    logic [3:0]        way_valid;
    logic [4*HALT_W-1:0] halt_tag_i;
    logic [4*MAIN_W-1:0] main_tag_i;
    logic              resp_valid, hit, miss;
    logic [1:0]        hit_way;
    logic              mem_req;
    logic [TAG_W-1:0]  mem_tag;
    logic              mem_ack;
    logic              tag_we;
    logic [3:0]        way_sel;
    logic [HALT_W-1:0] wr_halt_tag;
    logic [MAIN_W-1:0] wr_main_tag;
    logic [CNT_W-1:0]  main_cmp_cnt;
    logic              multi_hit;

    logic [HALT_W-1:0] m_halt [4];
    logic [MAIN_W-1:0] m_main [4];
    logic [3:0]        m_valid;

    typedef struct packed { logic hit; logic [1:0] way; } exp_t;
    exp_t sb_q [$];

    int n_cmp = 0;
    int n_err = 0;

    halt_tag_lookup_ctrl #(.HALT_W(HALT_W), .MAIN_W(MAIN_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .lkp_valid(lkp_valid), .lkp_ready(lkp_ready), .lkp_tag(lkp_tag),
        .way_valid(way_valid), .halt_tag_i(halt_tag_i), .main_tag_i(main_tag_i),
        .resp_valid(resp_valid), .hit(hit), .miss(miss), .hit_way(hit_way),
        .mem_req(mem_req), .mem_tag(mem_tag), .mem_ack(mem_ack),
        .tag_we(tag_we), .way_sel(way_sel),
        .wr_halt_tag(wr_halt_tag), .wr_main_tag(wr_main_tag),
        .main_cmp_cnt(main_cmp_cnt), .multi_hit(multi_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        way_valid = m_valid;
        for (int w = 0; w < 4; w++) begin
            halt_tag_i[w*HALT_W +: HALT_W] = m_halt[w];
            main_tag_i[w*MAIN_W +: MAIN_W] = m_main[w];
        end
    end

    task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", nm, obs, exp);
        end
    endtask

    task automatic set_way(input int w, input logic [HALT_W-1:0] h, input logic [MAIN_W-1:0] m);
        m_halt[w] = h;
        m_main[w] = m;
    endtask

    task automatic lookup(input logic [TAG_W-1:0] tag, input logic exp_hit, input logic [1:0] exp_way,
                          input logic [CNT_W-1:0] exp_cnt, input logic exp_multi, input int ack_wait);
        exp_t e;
        int   n, waited;
        bit   got, saw_req, saw_we;
        sb_q.push_back('{hit: exp_hit, way: exp_way});
        @(negedge clk);
        chk("idle_ready", lkp_ready, 1);
        lkp_valid = 1'b1;
        lkp_tag   = tag;
        @(negedge clk);
        lkp_valid = 1'b0;
        n = 1; waited = 0; got = 0; saw_req = 0; saw_we = 0;
        while (!got && n < 60) begin
            if (n == 1) chk("busy_ready", lkp_ready, 0);
            if (mem_req) begin
                if (!saw_req) begin
                    saw_req = 1;
                    chk("mem_tag", mem_tag, tag);
                end
                if (waited == ack_wait) mem_ack = 1'b1;
                else waited++;
            end else begin
                mem_ack = 1'b0;
            end
            if (tag_we) begin
                saw_we = 1;
                chk("way_sel", way_sel, 32'(4'b0001 << exp_way));
                chk("wr_halt_tag", wr_halt_tag, tag[HALT_W-1:0]);
                chk("wr_main_tag", wr_main_tag, tag[TAG_W-1:HALT_W]);
                for (int w = 0; w < 4; w++)
                    if (way_sel[w]) begin
                        m_halt[w]  = wr_halt_tag;
                        m_main[w]  = wr_main_tag;
                        m_valid[w] = 1'b1;
                    end
            end
            if (resp_valid) begin
                got = 1;
                if (sb_q.size() == 0) begin
                    chk("sb_underflow", 0, 1);
                end else begin
                    e = sb_q.pop_front();
                    chk("resp_hit", hit, e.hit);
                    chk("resp_miss", miss, !e.hit);
                    chk("resp_way", hit_way, e.way);
                    if (e.hit) chk("hit_latency", n, 3);
                    chk("refill_seen", saw_req, !e.hit);
                    chk("write_seen", saw_we, !e.hit);
                end
            end
            if (!got) begin
                @(negedge clk);
                n++;
            end
        end
        if (!got) chk("resp_timeout", 0, 1);
        mem_ack = 1'b0;
        @(negedge clk);
        chk("resp_one_cycle", resp_valid, 0);
        chk("cmp_cnt", main_cmp_cnt, exp_cnt);
        chk("multi_hit", multi_hit, exp_multi);
    endtask

    initial begin
        bit seen_we;
        reset     = 1'b0;
        lkp_valid = 1'b0;
        lkp_tag   = '0;
        mem_ack   = 1'b0;
        m_valid   = 4'b1111;
        set_way(0, 4'h1, 20'h11111);
        set_way(1, 4'h2, 20'h22222);
        set_way(2, 4'h5, 20'h12345);
        set_way(3, 4'h7, 20'h77777);
        repeat (3) @(negedge clk);
        chk("rst_ready", lkp_ready, 1);
        chk("rst_resp", resp_valid, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_tag_we", tag_we, 0);
        chk("rst_way_sel", way_sel, 0);
        chk("rst_cnt", main_cmp_cnt, 0);
        chk("rst_multi", multi_hit, 0);
        reset = 1'b1;

        // Single-survivor hit on way2.
        lookup(24'h123455, 1'b1, 2'd2, 16'd1, 1'b0, 0);
        // Early miss, all valid: round-robin victim way0, long memory wait.
        lookup(24'hABCDEA, 1'b0, 2'd0, 16'd1, 1'b0, 5);
        // The refilled tag now hits in way0.
        lookup(24'hABCDEA, 1'b1, 2'd0, 16'd2, 1'b0, 0);
        // Invalid way2 is the victim; pointer must stay at 1.
        m_valid = 4'b1011;
        lookup(24'h999990, 1'b0, 2'd2, 16'd2, 1'b0, 1);
        // Halt survivor on way2 but main mismatch: miss, victim from pointer (way1).
        lookup(24'h888880, 1'b0, 2'd1, 16'd3, 1'b0, 0);

        // All halt tags equal: every way compared.
        m_valid = 4'b1111;
        set_way(0, 4'h3, 20'hA0000);
        set_way(1, 4'h3, 20'hA0001);
        set_way(2, 4'h3, 20'hA0002);
        set_way(3, 4'h3, 20'hA0003);
        lookup(24'hA00033, 1'b1, 2'd3, 16'd7, 1'b0, 0);
        // Duplicate full tag in ways 1 and 2.
        set_way(2, 4'h3, 20'hA0001);
        lookup(24'hA00013, 1'b1, 2'd1, 16'd11, 1'b1, 0);
        lookup(24'hA00033, 1'b1, 2'd3, 16'd15, 1'b1, 0);

        // Reset during REFILL.
        @(negedge clk);
        lkp_valid = 1'b1;
        lkp_tag   = 24'h55555F;
        @(negedge clk);
        lkp_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_rst_mem_req", mem_req, 1);
        #2 reset = 1'b0;
        #1;
        chk("async_mem_req", mem_req, 0);
        chk("async_ready", lkp_ready, 1);
        chk("async_cnt", main_cmp_cnt, 0);
        chk("async_multi", multi_hit, 0);
        @(negedge clk);
        reset   = 1'b1;
        mem_ack = 1'b1;
        seen_we = 0;
        @(negedge clk);
        mem_ack = 1'b0;
        repeat (4) begin
            if (tag_we || resp_valid) seen_we = 1;
            @(negedge clk);
        end
        chk("stale_ack_write", seen_we, 0);

        lookup(24'hA00033, 1'b1, 2'd3, 16'd4, 1'b0, 0);
        chk("sb_empty", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/halt_tag_lookup_ctrl.md
Name: halt_tag_lookup_ctrl

Overview:
Lookup and refill controller for one 4-way set of the way-halting cache.
- Consumes the per-way outputs of the halt-tag (4-bit) and main-tag (20-bit) register arrays.
- Halt tags filter ways first; the full main-tag compare runs only on ways that survive.
- On a miss, runs a memory refill handshake, then drives the tag arrays' write enable and per-way decode to install the new tag.

Parameters:
HALT_W, 4, halt-tag width; equals the low bits of the lookup tag.
MAIN_W, 20, main-tag width; equals the upper bits of the lookup tag.
CNT_W, 16, width of the saturating main-compare counter.
Way count is fixed at 4.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-low reset.
lkp_valid  in  1  lookup request.
lkp_ready  out  1  controller can accept a lookup (high only in IDLE).
lkp_tag  in  HALT_W+MAIN_W  lookup tag; [HALT_W-1:0] is the halt tag, upper bits are the main tag.
way_valid  in  4  valid bit per way.
halt_tag_i  in  4*HALT_W  halt-tag array outputs; way w occupies [w*HALT_W +: HALT_W].
main_tag_i  in  4*MAIN_W  main-tag array outputs; way w occupies [w*MAIN_W +: MAIN_W].
resp_valid  out  1  one-cycle response strobe.
hit  out  1  response is a hit.
miss  out  1  response is a miss (refill already done).
hit_way  out  2  hit way, or refilled way on a miss.
mem_req  out  1  refill request.
mem_tag  out  HALT_W+MAIN_W  tag being refilled.
mem_ack  in  1  refill complete.
tag_we  out  1  tag-array write enable (regWrite).
way_sel  out  4  one-hot per-way write decode (decOut1b).
wr_halt_tag  out  HALT_W  halt tag to write.
wr_main_tag  out  MAIN_W  main tag to write.
main_cmp_cnt  out  CNT_W  count of main-tag way compares, saturating.
multi_hit  out  1  sticky error flag.

Behaviour:
- States: IDLE, HALT, CMP, REFILL, WRITE, RESP.
- Reset (async assert, any state): state returns to IDLE. Every output is 0 except lkp_ready, which is 1. Latched tag, halt-match vector, round-robin pointer and main_cmp_cnt all clear to 0. An in-flight refill is abandoned and mem_req drops immediately.
- IDLE: lkp_ready=1. A lookup is accepted when lkp_valid=1 on an edge; lkp_tag is latched and the state moves to HALT. lkp_valid is ignored in every other state.
- HALT (1 cycle): halt_match_q[w] is registered as way_valid[w] AND (halt tag of way w equals latched halt tag). Next state is CMP.
- CMP (1 cycle):
  - If halt_match_q is 0: early miss, no main compare, main_cmp_cnt unchanged, next state REFILL.
  - Otherwise compare main tags only for ways where halt_match_q is 1. main_cmp_cnt increases by popcount(halt_match_q) and saturates at all-ones.
  - Any main match gives a hit. hit_way is the lowest matching index; next state RESP.
  - More than one main match sets multi_hit; it stays set until reset.
  - No main match: next state REFILL.
- Victim selection (latched on entry to REFILL): the lowest-index way with way_valid=0. If all ways are valid, the way at the round-robin pointer is chosen and the pointer then increments mod 4. The pointer does not move when an invalid way is chosen.
- REFILL: mem_req=1 and mem_tag holds the latched tag. Both stay stable until mem_ack=1 is sampled; the state then moves to WRITE. mem_ack outside REFILL is ignored.
- WRITE (1 cycle): tag_we=1, way_sel is one-hot for the victim, and wr_halt_tag/wr_main_tag carry the latched tag. The tag arrays capture on the edge that ends WRITE. Next state RESP.
- RESP (1 cycle): resp_valid=1 with hit/miss/hit_way valid. Exactly one of hit or miss is 1; on a miss, hit_way is the victim. Next state IDLE.
- tag_we, way_sel, mem_req, resp_valid, hit and miss are all 0 outside their own states.
- Latency: accept at edge T, response at T+3 for a hit. A miss takes 4 cycles plus the memory wait until mem_ack.
- Back-to-back lookups: a new lookup is accepted at the earliest in the IDLE cycle after RESP.

Test Plan:
1. Reset, then load way2 with halt 0x5, main 0x12345, all ways valid; look up tag 0x123455 -> resp_valid at T+3, hit=1, hit_way=2, main_cmp_cnt=1 (only way2 passed the halt filter).
2. All ways valid, no halt tag equal to 0xA; look up 0xABCDEA -> early miss, main_cmp_cnt unchanged, mem_req=1 with mem_tag=0xABCDEA; hold mem_ack low 5 cycles then pulse it -> one WRITE cycle with tag_we=1, way_sel=0001 (pointer 0), then resp miss=1, hit_way=0, pointer becomes 1.
3. way_valid=1011; miss -> victim way2, way_sel=0100, round-robin pointer unchanged.
4. All four halt tags 0x3 with different main tags; hit on way3 -> main_cmp_cnt increases by 4, hit_way=3.
5. Two ways with an identical full tag -> hit_way is the lower index and multi_hit latches to 1, staying 1 through later lookups until reset.
6. Assert reset low while in REFILL with mem_req=1 -> mem_req=0 immediately (asynchronously), state IDLE, lkp_ready=1; a later mem_ack produces no tag_we.
